basys_input_capture: RTL and testbench

//  Input-side companion to the 7-segment display driver. Conditions Basys3 push-buttons and slide switches.

---
 rtl/basys_input_capture_pkg.sv | 18 +
 rtl/basys_input_capture_debounce_cell.sv | 115 +++++++++++
 rtl/basys_input_capture.sv | 88 ++++++++
 tb/tb_basys_input_capture.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/basys_input_capture_pkg.sv
// Shared definitions for the Basys3 input-capture slice.
// Holds the per-button debounce state encoding and the default debounce
// timing (1 ms at 100 MHz). The decoder-side logic uses the same defaults.
package basys_input_capture_pkg;

  // Debounce FSM states; the encoding is fixed so that other logic
  // (and waveform viewers) can decode state values directly.
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b10,
    WAIT_LOW  = 2'b11
  } btn_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 100000;
  localparam int DEF_CNT_W           = 17;

endpackage

// File: rtl/basys_input_capture_debounce_cell.sv
// debounce_cell: conditions one push-button.
// Raw pin -> 2-FF synchronizer -> debounce FSM with stability counter.
// The level and the one-cycle press/release pulses are all registered.
// Ports:
//   clk          in   system clock, posedge
//   reset_n      in   asynchronous active-low reset
//   btn_raw      in   raw, bouncing button pin
//   btn_level    out  debounced level
//   btn_press    out  one-cycle pulse on an accepted 0->1 change
//   btn_release  out  one-cycle pulse on an accepted 1->0 change
module debounce_cell
  import basys_input_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  btn_state_e       r_state;
  btn_state_e       w_stateNext;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;
  logic             r_level;
  logic             w_levelNext;
  logic             r_press;
  logic             w_pressNext;
  logic             r_release;
  logic             w_releaseNext;

  // Synchronizer, FSM state, counter and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_state   <= IDLE_LOW;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_s1      <= btn_raw;
      r_s2      <= r_s1;
      r_state   <= w_stateNext;
      r_cnt     <= w_cntNext;
      r_level   <= w_levelNext;
      r_press   <= w_pressNext;
      r_release <= w_releaseNext;
    end
  end

  // A new level is accepted only after the synchronized input has stayed
  // at it through the whole wait window; any glitch back restarts from IDLE.
  // The counter stops at CNT_LAST because acceptance leaves the WAIT state.
  always_comb begin
    w_stateNext   = r_state;
    w_cntNext     = r_cnt;
    w_levelNext   = r_level;
    w_pressNext   = 1'b0;
    w_releaseNext = 1'b0;
    case (r_state)
      IDLE_LOW: begin
        if (r_s2) begin
          w_stateNext = WAIT_HIGH;
          w_cntNext   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!r_s2) begin
          w_stateNext = IDLE_LOW;
        end else if (r_cnt == CNT_LAST) begin
          w_stateNext = IDLE_HIGH;
          w_levelNext = 1'b1;
          w_pressNext = 1'b1;
        end else begin
          w_cntNext = r_cnt + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!r_s2) begin
          w_stateNext = WAIT_LOW;
          w_cntNext   = '0;
        end
      end
      WAIT_LOW: begin
        if (r_s2) begin
          w_stateNext = IDLE_HIGH;
        end else if (r_cnt == CNT_LAST) begin
          w_stateNext   = IDLE_LOW;
          w_levelNext   = 1'b0;
          w_releaseNext = 1'b1;
        end else begin
          w_cntNext = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_stateNext = IDLE_LOW;
      end
    endcase
  end

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;

endmodule

// File: rtl/basys_input_capture.sv
// basys_input_capture: Basys3 button and switch conditioning.
// Buttons: one debounce_cell each (sync, debounce, press/release pulses).
// Switches: 2-FF synchronized, then snapshotted on a LOAD button press into
// a valid/ack holding register with a sticky overrun flag.
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset
//   btn_raw        raw button pins           -> btn_level/btn_press/btn_release
//   sw_raw         raw switch pins           -> sw_sync (synchronized only)
//   sw_data        snapshot taken on LOAD press
//   sw_valid       snapshot pending until sw_ack
//   sw_ack         consumer has taken sw_data
//   sw_overrun     sticky: LOAD arrived while a snapshot was still pending
module basys_input_capture
  import basys_input_capture_pkg::*;
#(
  parameter int NBTN            = 5,
  parameter int NSW             = 16,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int LOAD_IDX        = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NBTN-1:0] btn_raw,
  input  logic [NSW-1:0]  sw_raw,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] btn_release,
  output logic [NSW-1:0]  sw_sync,
  output logic [NSW-1:0]  sw_data,
  output logic            sw_valid,
  input  logic            sw_ack,
  output logic            sw_overrun
);

  logic [NSW-1:0] r_swS1;
  logic [NSW-1:0] r_swS2;
  logic [NSW-1:0] r_swData;
  logic           r_swValid;
  logic           r_swOverrun;
  logic           w_load;

  for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_cell (
      .clk        (clk),
      .reset_n    (reset_n),
      .btn_raw    (btn_raw[gi]),
      .btn_level  (btn_level[gi]),
      .btn_press  (btn_press[gi]),
      .btn_release(btn_release[gi])
    );
  end

  assign w_load = btn_press[LOAD_IDX];

  // Switch synchronizer plus snapshot handshake. A load always wins over an
  // ack in the same cycle, and the newest switch value always overwrites.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_swS1      <= '0;
      r_swS2      <= '0;
      r_swData    <= '0;
      r_swValid   <= 1'b0;
      r_swOverrun <= 1'b0;
    end else begin
      r_swS1 <= sw_raw;
      r_swS2 <= r_swS1;
      if (w_load) begin
        r_swData  <= r_swS2;
        r_swValid <= 1'b1;
        if (r_swValid && !sw_ack) begin
          r_swOverrun <= 1'b1;
        end
      end else if (sw_ack) begin
        r_swValid <= 1'b0;
      end
    end
  end

  assign sw_sync    = r_swS2;
  assign sw_data    = r_swData;
  assign sw_valid   = r_swValid;
  assign sw_overrun = r_swOverrun;

endmodule

// File: tb/tb_basys_input_capture.sv
// Self-checking bench for basys_input_capture with a short debounce window.
// A run-length reference model predicts every output after every edge;
// directed steps additionally pin the documented cycle timings.
module tb_basys_input_capture;

  localparam int NBTN = 5;
  localparam int NSW  = 16;
  localparam int DEB  = 4;
  localparam int CNTW = 3;
  localparam int LOADI = 0;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic [NBTN-1:0] btn_raw = '0;
  logic [NSW-1:0]  sw_raw = '0;
  logic            sw_ack = 1'b0;
  logic [NBTN-1:0] btn_level;
  logic [NBTN-1:0] btn_press;
  logic [NBTN-1:0] btn_release;
  logic [NSW-1:0]  sw_sync;
  logic [NSW-1:0]  sw_data;
  logic            sw_valid;
  logic            sw_overrun;

  basys_input_capture #(
    .NBTN(NBTN), .NSW(NSW), .DEBOUNCE_CYCLES(DEB), .CNT_W(CNTW), .LOAD_IDX(LOADI)
  ) dut (
    .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw), .sw_raw(sw_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .sw_sync(sw_sync), .sw_data(sw_data), .sw_valid(sw_valid),
    .sw_ack(sw_ack), .sw_overrun(sw_overrun)
  );

  always #5 clk = ~clk;

  // Reference model: two-stage sample delay, then a level flips once the
  // delayed samples disagree with it for DEB+1 consecutive edges.
  logic [NBTN-1:0] mS1, mS2, mLevel, mPress, mRel;
  int              mRun [NBTN];
  logic [NSW-1:0]  mSw1, mSw2, mData;
  logic            mValid, mOver;

  int nChecks = 0;
  int nFails  = 0;

  task automatic modelClear();
    mS1 = '0; mS2 = '0; mLevel = '0; mPress = '0; mRel = '0;
    for (int b = 0; b < NBTN; b++) mRun[b] = 0;
    mSw1 = '0; mSw2 = '0; mData = '0; mValid = 1'b0; mOver = 1'b0;
  endtask

  task automatic modelEdge();
    logic oldLoad;
    logic [NSW-1:0] oldSync;
    if (!reset_n) begin
      modelClear();
      return;
    end
    oldLoad = mPress[LOADI];
    oldSync = mSw2;
    for (int b = 0; b < NBTN; b++) begin
      mPress[b] = 1'b0;
      mRel[b]   = 1'b0;
      if (mS2[b] != mLevel[b]) begin
        mRun[b]++;
        if (mRun[b] == DEB + 1) begin
          mLevel[b] = mS2[b];
          if (mS2[b]) mPress[b] = 1'b1;
          else        mRel[b]   = 1'b1;
          mRun[b] = 0;
        end
      end else begin
        mRun[b] = 0;
      end
    end
    if (oldLoad) begin
      if (mValid && !sw_ack) mOver = 1'b1;
      mData  = oldSync;
      mValid = 1'b1;
    end else if (sw_ack) begin
      mValid = 1'b0;
    end
    mS2 = mS1; mS1 = btn_raw;
    mSw2 = mSw1; mSw1 = sw_raw;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string phase);
    checkOutput({phase, ":btn_level"},   32'(btn_level),   32'(mLevel));
    checkOutput({phase, ":btn_press"},   32'(btn_press),   32'(mPress));
    checkOutput({phase, ":btn_release"}, 32'(btn_release), 32'(mRel));
    checkOutput({phase, ":sw_sync"},     32'(sw_sync),     32'(mSw2));
    checkOutput({phase, ":sw_data"},     32'(sw_data),     32'(mData));
    checkOutput({phase, ":sw_valid"},    32'(sw_valid),    32'(mValid));
    checkOutput({phase, ":sw_overrun"},  32'(sw_overrun),  32'(mOver));
  endtask

  // Drive inputs away from the edge, clock once, then compare.
  task automatic applyStimulus(input string phase, input logic [NBTN-1:0] b,
                               input logic [NSW-1:0] s, input logic a);
    btn_raw = b;
    sw_raw  = s;
    sw_ack  = a;
    @(posedge clk);
    modelEdge();
    #1;
    checkAll(phase);
  endtask

  initial begin
    logic [4:0] bouncePat;
    int         pulses;
    logic [NBTN-1:0] target;
    int         bounceLeft [NBTN];
    logic [NSW-1:0] swRand;

    // Asynchronous reset with everything driven high and no clock edge yet.
    btn_raw = 5'h1F;
    sw_raw  = 16'hFFFF;
    #1 reset_n = 1'b0;
    #1;
    modelClear();
    checkAll("reset_async");
    checkOutput("reset_press_zero", 32'(btn_press), 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus("reset_held", 5'h1F, 16'hFFFF, 1'b0);
    reset_n = 1'b1;
    applyStimulus("idle", '0, '0, 1'b0);
    applyStimulus("idle", '0, '0, 1'b0);
    applyStimulus("idle", '0, '0, 1'b0);

    // Clean press and release on button 2.
    for (int i = 1; i <= 10; i++) begin
      applyStimulus("clean_press", 5'b00100, '0, 1'b0);
      checkOutput($sformatf("press2_e%0d", i), 32'(btn_press[2]), 32'(i == 7));
      checkOutput($sformatf("level2_e%0d", i), 32'(btn_level[2]), 32'(i >= 7));
    end
    for (int i = 0; i < 10; i++) applyStimulus("held", 5'b00100, '0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus("clean_release", '0, '0, 1'b0);
      checkOutput($sformatf("release2_e%0d", i), 32'(btn_release[2]), 32'(i == 7));
      checkOutput($sformatf("rlevel2_e%0d", i), 32'(btn_level[2]), 32'(i < 7));
    end

    // Bounce on button 1: 1,1,0,1,0 then steady 1 from sample edge 6.
    bouncePat = 5'b01011;
    pulses = 0;
    for (int i = 1; i <= 16; i++) begin
      applyStimulus("bounce", (i <= 5) ? {3'b000, bouncePat[i-1], 1'b0} : 5'b00010, '0, 1'b0);
      if (btn_press[1]) pulses++;
      checkOutput($sformatf("bounce_press1_e%0d", i), 32'(btn_press[1]), 32'(i == 12));
    end
    checkOutput("bounce_pulse_count", 32'(pulses), 32'd1);
    for (int i = 0; i < 10; i++) applyStimulus("bounce_off", '0, '0, 1'b0);

    // Reset in the middle of WAIT_HIGH (counter at 2) with button 3 held.
    for (int i = 0; i < 5; i++) applyStimulus("mid_wait", 5'b01000, '0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    modelClear();
    checkAll("mid_reset_async");
    for (int i = 0; i < 3; i++) applyStimulus("mid_reset_held", 5'b01000, '0, 1'b0);
    reset_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus("after_reset", 5'b01000, '0, 1'b0);
      checkOutput($sformatf("rst_press3_e%0d", i), 32'(btn_press[3]), 32'(i == 7));
    end
    for (int i = 0; i < 10; i++) applyStimulus("rel3", '0, '0, 1'b0);

    // Snapshot on LOAD, then ack with switches changed.
    for (int i = 0; i < 10; i++) applyStimulus("snap", 5'b00001, 16'hA5C3, 1'b0);
    checkOutput("snap_data", 32'(sw_data), 32'h0000A5C3);
    checkOutput("snap_valid", 32'(sw_valid), 32'h1);
    for (int i = 0; i < 3; i++) applyStimulus("snap_hold", 5'b00001, 16'h0000, 1'b0);
    checkOutput("snap_valid_held", 32'(sw_valid), 32'h1);
    applyStimulus("ack", 5'b00001, 16'h0000, 1'b1);
    checkOutput("ack_valid", 32'(sw_valid), 32'h0);
    checkOutput("ack_data_kept", 32'(sw_data), 32'h0000A5C3);
    for (int i = 0; i < 10; i++) applyStimulus("rel0", '0, 16'h0000, 1'b0);

    // Second load makes valid pending again.
    for (int i = 0; i < 10; i++) applyStimulus("load2", 5'b00001, 16'h1111, 1'b0);
    checkOutput("load2_data", 32'(sw_data), 32'h00001111);
    for (int i = 0; i < 10; i++) applyStimulus("rel0b", '0, 16'h1111, 1'b0);

    // Load coincident with ack: valid stays set, no overrun.
    for (int i = 0; i < 10; i++)
      applyStimulus("coincident", 5'b00001, 16'h2222, mPress[LOADI]);
    checkOutput("coin_valid", 32'(sw_valid), 32'h1);
    checkOutput("coin_overrun", 32'(sw_overrun), 32'h0);
    checkOutput("coin_data", 32'(sw_data), 32'h00002222);
    for (int i = 0; i < 10; i++) applyStimulus("rel0c", '0, 16'h2222, 1'b0);

    // Load without ack while pending: overrun, newest data wins.
    for (int i = 0; i < 10; i++) applyStimulus("overrun", 5'b00001, 16'h3333, 1'b0);
    checkOutput("ovr_flag", 32'(sw_overrun), 32'h1);
    checkOutput("ovr_data", 32'(sw_data), 32'h00003333);
    for (int i = 0; i < 10; i++) applyStimulus("rel0d", '0, 16'h3333, 1'b1);
    checkOutput("ovr_sticky", 32'(sw_overrun), 32'h1);

    // Randomized buttons with bursts of bounce, random switches and acks.
    target = '0;
    swRand = 16'h0;
    for (int b = 0; b < NBTN; b++) bounceLeft[b] = 0;
    for (int i = 0; i < 1500; i++) begin
      logic [NBTN-1:0] drive;
      for (int b = 0; b < NBTN; b++) begin
        if ($urandom_range(0, 11) == 0) begin
          target[b] = ~target[b];
          bounceLeft[b] = $urandom_range(0, 4);
        end
        if (bounceLeft[b] > 0) begin
          drive[b] = 1'($urandom);
          bounceLeft[b]--;
        end else begin
          drive[b] = target[b];
        end
      end
      if ($urandom_range(0, 7) == 0) swRand = 16'($urandom);
      if (i == 700) begin
        #2 reset_n = 1'b0;
        #1;
        modelClear();
        checkAll("rand_reset");
        applyStimulus("rand_reset_held", drive, swRand, 1'b0);
        reset_n = 1'b1;
      end
      applyStimulus("random", drive, swRand, ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
